// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a small receive FIFO.
//
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, status bit 3 = perr).
//
// Ports:
//   clk   block clock
//   rst   synchronous active-high reset
//   rxd   asynchronous serial input, idles high
//   en    device select from the bus address decode
//   drw   1 = write, 0 = read (qualified by en)
//   addr  word offset: 0 = status/command, 1 = data
//   din   write data
//   dout  read data, combinational from registers
//   irq   high while the FIFO is non-empty (registered)
//
// Status word: {24'b0, count in [7:4], perr, ferr, ovr, ~empty}
// Command write (addr 0): din[0] pops one entry, din[1] clears error flags.
module uart_rx_mmio #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 57600,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        en,
  input  logic        drw,
  input  logic        addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(DIV);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  // 2-flop synchroniser; only rxs_q is used downstream
  logic rx_meta_q, rxs_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  // after a framing error the line must go high before the next start is armed
  logic            wait_q, wait_d;
  logic            push_req, ferr_set, perr_set, expire;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [DEPTH_LOG2:0]   fcnt_q, fcnt_d;
  logic                  ovr_q, ferr_q, irq_q;
  logic                  empty, full, pop_req, clr_req, do_pop, do_push;
  logic                  perr_flag;
  logic                  unused_din;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q;
`endif

  assign unused_din = ^din[31:2];
  assign expire     = (cnt_q == '0);

  // ---------------- receive FSM ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wait_d   = wait_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != S_IDLE && !expire) cnt_d = cnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rxs_q) wait_d = 1'b0;
        else if (!wait_q) begin
          state_d = S_START;
          cnt_d   = CW'(DIV/2);
        end
      end
      S_START: if (expire) begin
        if (!rxs_q) begin
          state_d = S_DATA;
          cnt_d   = CW'(DIV-1);
          bit_d   = 3'd0;
        end else begin
          state_d = S_IDLE;   // glitch, silently drop
        end
      end
      S_DATA: if (expire) begin
        sh_d  = {rxs_q, sh_q[7:1]};   // LSB first
        cnt_d = CW'(DIV-1);
        bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = S_PARITY;
`else
        if (bit_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (expire) begin
        par_d   = rxs_q;
        cnt_d   = CW'(DIV-1);
        state_d = S_STOP;
      end
`endif
      S_STOP: if (expire) begin
        state_d = S_IDLE;
        if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
          if (par_q != ^sh_q) perr_set = 1'b1;
          else                push_req = 1'b1;
`else
          push_req = 1'b1;
`endif
        end else begin
          ferr_set = 1'b1;
          wait_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FIFO / register control ----------------
  always_comb begin
    empty   = (fcnt_q == '0);
    full    = (fcnt_q == FULL);
    pop_req = en & drw & ~addr & din[0];
    clr_req = en & drw & ~addr & din[1];
    do_pop  = pop_req & ~empty;
    // a same-cycle pop frees the slot for a push into a full FIFO
    do_push = push_req & (~full | do_pop);
    fcnt_d  = fcnt_q;
    if (do_push && !do_pop)      fcnt_d = fcnt_q + 1'b1;
    else if (do_pop && !do_push) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      wait_q    <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      fcnt_q    <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      wait_q    <= wait_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      fcnt_q    <= fcnt_d;
      // set wins over a coincident clear
      ovr_q     <= (ovr_q & ~clr_req) | (push_req & ~do_push);
      ferr_q    <= (ferr_q & ~clr_req) | ferr_set;
      irq_q     <= (fcnt_d != '0);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= (perr_q & ~clr_req) | perr_set;
    end
  end
  assign perr_flag = perr_q;
`else
  assign perr_flag = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_set;
`endif

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= sh_q;
  end

  always_comb begin
    dout = '0;
    if (addr) dout[7:0] = empty ? 8'h00 : mem_q[rd_q];
    else      dout[7:0] = {4'(fcnt_q), perr_flag, ferr_q, ovr_q, ~empty};
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;
  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst, rxd, en, drw, addr;
  logic [31:0] din, dout;
  logic        irq;

  uart_rx_mmio #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .en(en), .drw(drw), .addr(addr),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: byte queue plus sticky flags
  byte unsigned mq[$];
  bit m_ovr, m_ferr, m_perr;

  function automatic logic [31:0] m_status();
    logic [3:0] c;
    c = 4'(mq.size());
    return {24'b0, c, m_perr, m_ferr, m_ovr, (mq.size() != 0)};
  endfunction

  function automatic logic [31:0] m_data();
    return (mq.size() == 0) ? 32'h0 : {24'b0, mq[0]};
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit stop, input bit pflip);
    if (!stop) m_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
    else if (pflip) m_perr = 1'b1;
`endif
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endfunction

  function automatic void m_write(input logic [31:0] d);
    if (d[0] && mq.size() != 0) void'(mq.pop_front());
    if (d[1]) begin m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    en = 1'b1; drw = 1'b0; addr = a;
    #1 v = dout;
    en = 1'b0; addr = 1'b0;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    en = 1'b1; drw = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    en = 1'b0; drw = 1'b0; addr = 1'b0; din = '0;
    if (!a) m_write(d);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pflip, input int gap);
    rxd = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(DIV); end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ pflip; tick(DIV);
`endif
    rxd = stop; tick(DIV);
    rxd = 1'b1; tick(gap);
    m_frame(b, stop, pflip);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; rxd = 1'b1; en = 1'b0; drw = 1'b0; addr = 1'b0; din = '0;
    tick(3);
    rst = 1'b0; tick(2);
    mq.delete(); m_ovr = 0; m_ferr = 0; m_perr = 0;
    rd(1'b0, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h0); end
    rd(1'b1, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", v, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_single();
    logic [31:0] v;
    send_frame(8'hA5, 1'b1, 1'b0, 4);
    rd(1'b0, v); checks++;
    if (v !== 32'h11) begin failures++; $display("FAIL single_status got=%h exp=%h", v, 32'h11); end
    rd(1'b1, v); checks++;
    if (v !== 32'hA5) begin failures++; $display("FAIL single_data got=%h exp=%h", v, 32'hA5); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL single_irq got=%b exp=1", irq); end
    wr(1'b0, 32'h1);
    rd(1'b0, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL single_pop got=%h exp=%h", v, 32'h0); end
    tick(1); checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0] e;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 4);
    rd(1'b0, v); checks++;
    if (v !== 32'h43) begin failures++; $display("FAIL ovr_status got=%h exp=%h", v, 32'h43); end
    for (int i = 1; i <= 4; i++) begin
      e = 8'(i);
      rd(1'b1, v); checks++;
      if (v !== {24'b0, e}) begin failures++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, v, {24'b0, e}); end
      wr(1'b0, 32'h1);
    end
    wr(1'b0, 32'h2);
    rd(1'b0, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL ovr_clear got=%h exp=%h", v, 32'h0); end
    // writes to the data register are ignored
    wr(1'b1, 32'h3);
    rd(1'b0, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL data_write_ignored got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    rxd = 1'b0; tick(4); rxd = 1'b1; tick(3 * DIV);
    rd(1'b0, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL glitch_status got=%h exp=%h", v, 32'h0); end
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    rd(1'b1, v); checks++;
    if (v !== 32'h5A) begin failures++; $display("FAIL glitch_next got=%h exp=%h", v, 32'h5A); end
    wr(1'b0, 32'h1);
  endtask

  task automatic test_ferr();
    logic [31:0] v;
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    rd(1'b0, v); checks++;
    if (v !== 32'h04) begin failures++; $display("FAIL ferr_status got=%h exp=%h", v, 32'h04); end
    send_frame(8'h7E, 1'b1, 1'b0, 4);
    rd(1'b0, v); checks++;
    if (v !== 32'h15) begin failures++; $display("FAIL ferr_next_status got=%h exp=%h", v, 32'h15); end
    rd(1'b1, v); checks++;
    if (v !== 32'h7E) begin failures++; $display("FAIL ferr_next_data got=%h exp=%h", v, 32'h7E); end
    wr(1'b0, 32'h3);
    rd(1'b0, v); checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL ferr_pop_clear got=%h exp=%h", v, 32'h0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] v;
    send_frame(8'h03, 1'b1, 1'b1, 4);
    rd(1'b0, v); checks++;
    if (v !== 32'h08) begin failures++; $display("FAIL perr_status got=%h exp=%h", v, 32'h08); end
    wr(1'b0, 32'h2);
    send_frame(8'h03, 1'b1, 1'b0, 4);
    rd(1'b1, v); checks++;
    if (v !== 32'h03) begin failures++; $display("FAIL parity_ok_data got=%h exp=%h", v, 32'h03); end
    wr(1'b0, 32'h1);
  endtask
`endif

  task automatic test_random();
    logic [31:0] v, e;
    logic [7:0]  b;
    bit stop, pflip;
    int npop;
    for (int it = 0; it < 24; it++) begin
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 5) != 0);
      pflip = 1'b0;
`ifdef UART_RX_PARITY_EN
      pflip = ($urandom_range(0, 5) == 0);
`endif
      send_frame(b, stop, pflip, 2 + $urandom_range(0, 6));
      rd(1'b0, v); e = m_status(); checks++;
      if (v !== e) begin failures++; $display("FAIL rand_status it=%0d got=%h exp=%h", it, v, e); end
      rd(1'b1, v); e = m_data(); checks++;
      if (v !== e) begin failures++; $display("FAIL rand_data it=%0d got=%h exp=%h", it, v, e); end
      checks++;
      if (irq !== (mq.size() != 0)) begin failures++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq, mq.size() != 0); end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        wr(1'b0, {30'b0, ($urandom_range(0, 3) == 0), 1'b1});
        rd(1'b0, v); e = m_status(); checks++;
        if (v !== e) begin failures++; $display("FAIL rand_pop it=%0d got=%h exp=%h", it, v, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_glitch();
    test_ferr();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
